tick_and_set_conditioner: RTL and testbench
===========================================

Name: tick_and_set_conditioner

Overview:
- Front-end stage that feeds the time-of-day counter.
- Converts the raw board clock into a 1 Hz count-enable pulse.
- Synchronises and debounces the set switch and a run/pause key.
- Validates the BCD time value on the switches and issues a single-cycle, already-legal "load" strobe with registered set fields. The counter stage then never sees bounce, metastability or out-of-range digits.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, tick_1hz pulse rate. CLK_HZ/TICK_HZ must be an integer ≥ 2.
- DEBOUNCE_CYCLES, 500_000, cycles a synchronised input must hold a new level before it is accepted (10 ms at 50 MHz). Must be ≥ 1.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers. Must be ≥ 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sw_in  input  10  raw slide switches: [3:0] ones digit, [7:4] tens digit, [8] set request, [9] 1 = hours, 0 = minutes
- key_run_n  input  1  raw push-button, active-low; each press toggles run/pause
- tick_1hz  output  1  one-cycle count enable for the seconds counter
- run  output  1  1 = clock counting, 0 = paused
- set_strobe  output  1  one-cycle load command carrying a legal value
- set_error  output  1  one-cycle pulse when a set request carries an illegal value
- set_hour_sel  output  1  latched sw_in[9] at the strobe or error
- set_tens  output  4  latched tens digit
- set_ones  output  4  latched ones digit

Behaviour:
- Reset (asynchronous, active-high): all outputs 0 except run=1. Prescaler, debounce counters, synchroniser flops and debounced states all clear to 0 (key treated as released, set switch as low).
- Synchronisation:
  - Every sw_in bit and key_run_n pass through SYNC_STAGES flops.
  - Digit and select bits are used only in synchronised form.
- Debounce (applies to sync'd sw_in[8] and sync'd ~key_run_n):
  - Per-channel counter. If sync level == debounced state, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced state takes the new level and the counter clears on the next cycle.
  - A glitch shorter than DEBOUNCE_CYCLES resets progress and produces no change.
- Edge events:
  - Debounced set switch rising edge gives set_req for one cycle.
  - Debounced key rising edge (press) toggles run.
  - Release and falling edges do nothing.
- Validation on set_req, using the sync'd digits:
  - Hours are legal iff tens ≤ 2, ones ≤ 9, and (tens != 2 or ones ≤ 3).
  - Minutes are legal iff tens ≤ 5 and ones ≤ 9.
  - Legal value: set_strobe=1 for one cycle, registered in the cycle after set_req.
  - Illegal value: set_error=1 for one cycle instead. Never both.
  - set_hour_sel, set_tens and set_ones are loaded in the same cycle as the strobe or error pulse and held until the next set_req.
- Latency: a clean level change on sw_in[8] produces set_strobe exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk edges after the first edge that samples the new level. The bench must check this to the cycle.
- Prescaler:
  - Counts 0 .. CLK_HZ/TICK_HZ-1 while run=1, and holds its value while run=0.
  - tick_1hz=1 in the cycle the count equals the terminal value, after which the count wraps to 0.
  - tick_1hz is never asserted while run=0.
- Simultaneous events:
  - set_strobe cycle coinciding with terminal count: the tick is suppressed and the prescaler clears to 0, so a full second elapses after a load. Every set_strobe clears the prescaler.
  - set_error does not touch the prescaler.
  - A run toggle in the same cycle as terminal count: the tick is still issued, and the pause takes effect from the next cycle.
- Reset mid-operation: in-flight debounce progress is lost. If sw_in[8] is held high through reset release, one set_strobe (or set_error) follows after the full latency. This is intended.

Decomposition:
- Shared package clock_pkg holds:
  - bcd_t (4-bit digit) typedef.
  - Constants HOUR_TENS_MAX=2, HOUR_ONES_MAX_AT_20=3, MIN_TENS_MAX=5, DIGIT_MAX=9.
  - The default CLK_HZ.
  - The same constants are reused by the counter stage.
- One sub-module, debounce_bit:
  - Parameters SYNC_STAGES and DEBOUNCE_CYCLES; ports clk, reset, din, dout, rise.
  - Instantiated twice: set switch and run key.
- The top level keeps the prescaler, validator and output registers.

Test Plan (bench uses CLK_HZ=10, TICK_HZ=1, DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Free-run: no inputs for 35 cycles after reset -> tick_1hz pulses at cycles 10, 20, 30, each 1 cycle wide; run=1; no strobes.
- Legal hour set: sw_in[9]=1, [7:4]=2, [3:0]=3, then raise [8] and hold -> exactly one set_strobe, 7 edges after sampling; set_hour_sel=1, tens=2, ones=3. The prescaler restarts, so the next tick comes 10 cycles after the strobe.
- Illegal minute set: sw_in[9]=0, tens=6, ones=0, raise [8] -> one set_error pulse, no set_strobe; fields read 0/6/0; tick spacing unchanged.
- Bounce: toggle sw_in[8] high/low every 2 cycles for 20 cycles, then settle low -> no strobe and no error.
- Run/pause: a 6-cycle low pulse on key_run_n -> run goes to 0 and no ticks appear while paused. A second press -> run goes to 1, and the tick resumes from the held count rather than 0.
- Async reset: assert reset mid-count with run=0 and fields loaded -> all outputs clear immediately without a clk edge, run=1. The first tick comes 10 cycles after release.

Source files
------------

// File: rtl/tick_and_set_conditioner_pkg.sv
// Shared time-of-day definitions: BCD digit type, legal-range limits and the
// default board clock. The counter stage imports the same limits.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

  localparam bcd_t HOUR_TENS_MAX       = 4'd2;
  localparam bcd_t HOUR_ONES_MAX_AT_20 = 4'd3;
  localparam bcd_t MIN_TENS_MAX        = 4'd5;
  localparam bcd_t DIGIT_MAX           = 4'd9;

  // Hours 00..23, minutes 00..59; any non-decimal nibble is rejected.
  function automatic logic bcd_time_legal(input logic hour_sel, input bcd_t tens, input bcd_t ones);
    if (ones > DIGIT_MAX) return 1'b0;
    if (hour_sel)
      return (tens < HOUR_TENS_MAX) || ((tens == HOUR_TENS_MAX) && (ones <= HOUR_ONES_MAX_AT_20));
    return tens <= MIN_TENS_MAX;
  endfunction

endpackage

// File: rtl/tick_and_set_conditioner_if.sv
// Board-side switch/key inputs and the conditioned tick/run/set outputs.
interface tick_and_set_conditioner_if;
  import clock_pkg::*;

  logic [9:0] sw_in;
  logic       key_run_n;
  logic       tick_1hz;
  logic       run;
  logic       set_strobe;
  logic       set_error;
  logic       set_hour_sel;
  bcd_t       set_tens;
  bcd_t       set_ones;

  modport master (
    output sw_in, key_run_n,
    input  tick_1hz, run, set_strobe, set_error, set_hour_sel, set_tens, set_ones
  );

  modport slave (
    input  sw_in, key_run_n,
    output tick_1hz, run, set_strobe, set_error, set_hour_sel, set_tens, set_ones
  );

endinterface

// File: rtl/tick_and_set_conditioner_debounce_bit.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a hold-time
// debouncer. rise pulses for one cycle in the cycle dout first reads 1.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any return to the accepted level throws away the progress made so far.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      dout   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      if (synced == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= synced;
        rise <= synced;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_and_set_conditioner.sv
// Front end of the time-of-day clock: 1 Hz count enable, debounced run/pause
// toggle and a validated, single-cycle set/load strobe with registered fields.
module tick_and_set_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  tick_and_set_conditioner_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int          PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [SYNC_STAGES-1:0][8:0] fld_sync;
  logic [8:0] fld;
  logic       set_level, set_req;
  logic       key_level, key_rise;
  logic       legal;

  logic          run_q, strobe_q, error_q, hour_q;
  bcd_t          tens_q, ones_q;
  logic [PW-1:0] pre_cnt;
  logic          terminal;

  // Digits and hour/minute select only need metastability protection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fld_sync <= '0;
    else       fld_sync <= {fld_sync[SYNC_STAGES-2:0], {bus.sw_in[9], bus.sw_in[7:0]}};
  end

  assign fld = fld_sync[SYNC_STAGES-1];

  debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk(clk), .reset(reset), .din(bus.sw_in[8]), .dout(set_level), .rise(set_req)
  );

  debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk(clk), .reset(reset), .din(~bus.key_run_n), .dout(key_level), .rise(key_rise)
  );

  // Only the press/raise edges act here; the settled levels are not needed.
  logic unused_levels;
  assign unused_levels = set_level ^ key_level;

  assign legal    = bcd_time_legal(fld[8], fld[7:4], fld[3:0]);
  assign terminal = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q    <= 1'b1;
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
      hour_q   <= 1'b0;
      tens_q   <= '0;
      ones_q   <= '0;
      pre_cnt  <= '0;
    end else begin
      if (key_rise) run_q <= ~run_q;
      strobe_q <= set_req & legal;
      error_q  <= set_req & ~legal;
      if (set_req) begin
        hour_q <= fld[8];
        tens_q <= fld[7:4];
        ones_q <= fld[3:0];
      end
      // A load restarts the second so the first tick is a full period away.
      if (strobe_q)   pre_cnt <= '0;
      else if (run_q) pre_cnt <= terminal ? '0 : pre_cnt + 1'b1;
    end
  end

  assign bus.tick_1hz     = run_q & terminal & ~strobe_q;
  assign bus.run          = run_q;
  assign bus.set_strobe   = strobe_q;
  assign bus.set_error    = error_q;
  assign bus.set_hour_sel = hour_q;
  assign bus.set_tens     = tens_q;
  assign bus.set_ones     = ones_q;

endmodule

// File: tb/tb_tick_and_set_conditioner.sv
// Bench for tick_and_set_conditioner: directed stimulus, an event-level model
// compared every cycle, plus literal expectations for timing and fields.
module tb_tick_and_set_conditioner;
  import clock_pkg::*;

  localparam int CLK_HZ = 10, TICK_HZ = 1, DEB = 4, SYNC = 2;
  localparam int DIV = CLK_HZ / TICK_HZ;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tick_and_set_conditioner_if bus();

  tick_and_set_conditioner #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_strobe = 0, n_error = 0, n_tick = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model: raw-sample history plus event rules ----------------
  logic       h_set[$];
  logic       h_key[$];
  logic [8:0] h_fld[$];
  logic m_deb_set, m_deb_key, m_req_set, m_req_key;
  logic m_run, m_strobe, m_error, m_hour;
  logic [3:0] m_tens, m_ones;
  int   m_phase;  // cycles spent running since reset or the last load

  function automatic logic seen(input bit key, input int i);
    if (i - SYNC < 0) return 1'b0;
    return key ? h_key[i-SYNC] : h_set[i-SYNC];
  endfunction

  // New level accepted when DEB consecutive synchronised samples disagree with it.
  function automatic logic settles(input bit key, input int last, input logic deb);
    for (int k = 0; k < DEB; k++)
      if (seen(key, last - k) == deb) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic time_ok(input logic hour, input int tens, input int ones);
    if (ones > 9) return 1'b0;
    return hour ? (tens * 10 + ones <= 23) : (tens * 10 + ones <= 59);
  endfunction

  task automatic model_reset();
    h_set.delete(); h_key.delete(); h_fld.delete();
    m_deb_set = 0; m_deb_key = 0; m_req_set = 0; m_req_key = 0;
    m_run = 1; m_strobe = 0; m_error = 0; m_hour = 0; m_tens = 0; m_ones = 0;
    m_phase = 0;
  endtask

  task automatic model_step();
    int last, n_phase;
    logic n_run, n_strobe, n_error, flip;
    logic [8:0] f;
    h_set.push_back(bus.sw_in[8]);
    h_key.push_back(!bus.key_run_n);
    h_fld.push_back({bus.sw_in[9], bus.sw_in[7:0]});
    last = h_set.size() - 1;
    n_phase = m_strobe ? 0 : (m_run ? m_phase + 1 : m_phase);
    n_run = m_req_key ? !m_run : m_run;
    n_strobe = 0; n_error = 0;
    if (m_req_set) begin
      f = (last - SYNC >= 0) ? h_fld[last-SYNC] : 9'd0;
      if (time_ok(f[8], int'(f[7:4]), int'(f[3:0]))) n_strobe = 1; else n_error = 1;
      m_hour = f[8]; m_tens = f[7:4]; m_ones = f[3:0];
    end
    flip = settles(1'b0, last, m_deb_set);
    if (flip) m_deb_set = !m_deb_set;
    m_req_set = flip && m_deb_set;
    flip = settles(1'b1, last, m_deb_key);
    if (flip) m_deb_key = !m_deb_key;
    m_req_key = flip && m_deb_key;
    m_phase = n_phase; m_run = n_run; m_strobe = n_strobe; m_error = n_error;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // Every out-of-reset cycle: DUT against model, plus event tallies.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("tick_1hz", bus.tick_1hz, m_run && (m_phase % DIV == DIV - 1) && !m_strobe);
        check("run", bus.run, m_run);
        check("set_strobe", bus.set_strobe, m_strobe);
        check("set_error", bus.set_error, m_error);
        check("fields", {bus.set_hour_sel, bus.set_tens, bus.set_ones}, {m_hour, m_tens, m_ones});
        if (bus.set_strobe) n_strobe++;
        if (bus.set_error)  n_error++;
        if (bus.tick_1hz)   n_tick++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key();
    bus.key_run_n = 1'b0; cycles(6);
    bus.key_run_n = 1'b1; cycles(6);
  endtask

  int tick_cyc[$];
  int e, d, t0;

  initial begin
    bus.sw_in = '0;
    bus.key_run_n = 1'b1;
    cycles(3);
    reset = 1'b0;

    // free run: ticks in cycles 10, 20, 30 counted from reset release
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 1) check("reset_run", bus.run, 1);
      if (bus.tick_1hz) tick_cyc.push_back(k + 1);
    end
    check("free_tick_count", tick_cyc.size(), 3);
    for (int i = 0; i < 3 && i < tick_cyc.size(); i++)
      check("free_tick_cycle", tick_cyc[i], 10 * (i + 1));
    check("free_no_strobe", n_strobe + n_error, 0);

    // legal hour 23: strobe on the 7th edge counting the sampling edge
    bus.sw_in = {1'b1, 1'b0, 4'd2, 4'd3};
    cycles(4);
    bus.sw_in[8] = 1'b1;
    e = 0;
    while (e < 20) begin
      @(negedge clk); e++;
      if (bus.set_strobe) break;
    end
    check("strobe_latency", e, 7);
    check("hour_fields", {bus.set_hour_sel, bus.set_tens, bus.set_ones}, {1'b1, 4'd2, 4'd3});
    d = 0;
    while (d < 30) begin
      @(negedge clk); d++;
      if (bus.tick_1hz) break;
    end
    check("tick_after_load", d, 10);
    bus.sw_in[8] = 1'b0;
    cycles(10);
    check("legal_strobe_count", n_strobe, 1);

    // illegal minute 60
    bus.sw_in = {1'b0, 1'b0, 4'd6, 4'd0};
    cycles(4);
    bus.sw_in[8] = 1'b1;
    cycles(12);
    check("illegal_error_count", n_error, 1);
    check("illegal_no_strobe", n_strobe, 1);
    check("illegal_fields", {bus.set_hour_sel, bus.set_tens, bus.set_ones}, {1'b0, 4'd6, 4'd0});
    bus.sw_in[8] = 1'b0;
    cycles(10);

    // bounce on a legal minute value never settles
    bus.sw_in = {1'b0, 1'b0, 4'd4, 4'd5};
    cycles(4);
    for (int i = 0; i < 5; i++) begin
      bus.sw_in[8] = 1'b1; cycles(2);
      bus.sw_in[8] = 1'b0; cycles(2);
    end
    cycles(12);
    check("bounce_no_strobe", n_strobe, 1);
    check("bounce_no_error", n_error, 1);

    // run/pause
    press_key();
    check("paused", bus.run, 0);
    t0 = n_tick;
    cycles(15);
    check("no_tick_paused", n_tick - t0, 0);
    press_key();
    check("resumed", bus.run, 1);
    cycles(25);
    check("ticks_resumed", (n_tick - t0) > 0, 1);

    // async reset while paused with fields loaded
    press_key();
    check("pre_reset_run", bus.run, 0);
    check("pre_reset_tens", bus.set_tens, 6);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_run", bus.run, 1);
    check("async_outs", {bus.tick_1hz, bus.set_strobe, bus.set_error}, 0);
    check("async_fields", {bus.set_hour_sel, bus.set_tens, bus.set_ones}, 0);
    cycles(2);
    reset = 1'b0;
    d = 0;
    while (d < 30) begin
      @(negedge clk); d++;
      if (bus.tick_1hz) break;
    end
    check("reset_first_tick_cycle", d + 1, 10);
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
